// File: rtl/vga_scanout.sv
// VGA timing generator and registered DAC output stage. Pixel position is
// exposed as x/y for a combinational renderer; colour and syncs lag by one tick.
module vga_scanout #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       pixelEn,
  input  logic [7:0] r,
  input  logic [7:0] g,
  input  logic [7:0] b,
  output logic [9:0] x,
  output logic [8:0] y,
  output logic [7:0] vga_r,
  output logic [7:0] vga_g,
  output logic [7:0] vga_b,
  output logic       vga_hs,
  output logic       vga_vs,
  output logic       vga_blank_n,
  output logic       vga_sync_n,
  output logic       frameStart
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] HS_BEGIN = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] VS_BEGIN = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [9:0] h_cnt_q, h_cnt_d;
  logic [9:0] v_cnt_q, v_cnt_d;
  logic       active_s, hs_raw_s, vs_raw_s;
  logic [7:0] vga_r_q, vga_g_q, vga_b_q;
  logic       vga_hs_q, vga_vs_q, blank_n_q;

  assign active_s = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
  assign hs_raw_s = !((h_cnt_q >= HS_BEGIN) && (h_cnt_q <= HS_END));
  assign vs_raw_s = !((v_cnt_q >= VS_BEGIN) && (v_cnt_q <= VS_END));

  // Next position; >= comparisons keep the counters in range even from a corrupted state
  always_comb begin
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (pixelEn) begin
      if (h_cnt_q >= H_LAST) begin
        h_cnt_d = 10'd0;
        if (v_cnt_q >= V_LAST) begin
          v_cnt_d = 10'd0;
        end else begin
          v_cnt_d = v_cnt_q + 10'd1;
        end
      end else begin
        h_cnt_d = h_cnt_q + 10'd1;
      end
    end else begin
      h_cnt_d = h_cnt_q;
      v_cnt_d = v_cnt_q;
    end
  end

  // Position counters
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      h_cnt_q <= 10'd0;
      v_cnt_q <= 10'd0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  // DAC stage: colour is gated by the active region so blanking never leaks renderer data
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vga_r_q   <= 8'h00;
      vga_g_q   <= 8'h00;
      vga_b_q   <= 8'h00;
      vga_hs_q  <= 1'b1;
      vga_vs_q  <= 1'b1;
      blank_n_q <= 1'b0;
    end else if (pixelEn) begin
      vga_r_q   <= active_s ? r : 8'h00;
      vga_g_q   <= active_s ? g : 8'h00;
      vga_b_q   <= active_s ? b : 8'h00;
      vga_hs_q  <= hs_raw_s;
      vga_vs_q  <= vs_raw_s;
      blank_n_q <= active_s;
    end else begin
      vga_r_q   <= vga_r_q;
      vga_g_q   <= vga_g_q;
      vga_b_q   <= vga_b_q;
      vga_hs_q  <= vga_hs_q;
      vga_vs_q  <= vga_vs_q;
      blank_n_q <= blank_n_q;
    end
  end

  assign x           = h_cnt_q;
  assign y           = (v_cnt_q < V_ACT) ? v_cnt_q[8:0] : 9'd0;
  assign vga_r       = vga_r_q;
  assign vga_g       = vga_g_q;
  assign vga_b       = vga_b_q;
  assign vga_hs      = vga_hs_q;
  assign vga_vs      = vga_vs_q;
  assign vga_blank_n = blank_n_q;
  assign vga_sync_n  = 1'b0;
  // Marks the tick that registers pixel (0,0); forced low while reset is held
  assign frameStart  = reset_n & pixelEn & (h_cnt_q == 10'd0) & (v_cnt_q == 10'd0);

endmodule
